// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings decoded by the ALU, issue-stage states
// and datapath defaults used by the issue stage and its bypass muxes.
package alu_pkg;

    localparam int DEFAULT_WORD_SIZE  = 32;
    localparam int DEFAULT_REG_ADDR_W = 5;
    localparam int CNT_W              = 4;

    typedef enum logic [2:0] {
        ADD_OP = 3'd0,
        SUB_OP = 3'd1,
        MUL_OP = 3'd2,
        AND_OP = 3'd3,
        OR_OP  = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WAIT_MUL = 2'd1,
        VALID    = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-ALU issue bus: decode handshake, bypass buses, ALU operands and
// the downstream handshake. The issue stage uses the slave modport.
interface alu_issue_stage_if
    import alu_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_ctrl;
    logic [REG_ADDR_W-1:0] in_rs1_addr;
    logic [REG_ADDR_W-1:0] in_rs2_addr;
    logic [WORD_SIZE-1:0]  in_rs1_data;
    logic [WORD_SIZE-1:0]  in_rs2_data;
    logic [WORD_SIZE-1:0]  in_imm;
    logic                  in_use_imm;
    logic [REG_ADDR_W-1:0] in_rd_addr;
    logic                  in_rd_we;
    logic                  exm_we;
    logic [REG_ADDR_W-1:0] exm_addr;
    logic [WORD_SIZE-1:0]  exm_data;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [WORD_SIZE-1:0]  wb_data;
    logic [WORD_SIZE-1:0]  alu_a;
    logic [WORD_SIZE-1:0]  alu_b;
    logic [2:0]            alu_ctrl;
    logic                  out_valid;
    logic                  out_ready;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_rd_we;

    modport master (
        output flush, in_valid, in_ctrl, in_rs1_addr, in_rs2_addr,
               in_rs1_data, in_rs2_data, in_imm, in_use_imm, in_rd_addr,
               in_rd_we, exm_we, exm_addr, exm_data, wb_we, wb_addr,
               wb_data, out_ready,
        input  in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_rd_addr,
               out_rd_we
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_rs1_addr, in_rs2_addr,
               in_rs1_data, in_rs2_data, in_imm, in_use_imm, in_rd_addr,
               in_rd_we, exm_we, exm_addr, exm_data, wb_we, wb_addr,
               wb_data, out_ready,
        output in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_rd_addr,
               out_rd_we
    );

endinterface

// File: rtl/alu_issue_stage_operand_bypass.sv
// Priority operand mux: EX/MEM beats MEM/WB beats the fallback value, and
// register 0 is never forwarded.
module operand_bypass #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] addr_i,
    input  logic [WORD_SIZE-1:0]  rf_data_i,
    input  logic                  exm_we_i,
    input  logic [REG_ADDR_W-1:0] exm_addr_i,
    input  logic [WORD_SIZE-1:0]  exm_data_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [WORD_SIZE-1:0]  wb_data_i,
    output logic [WORD_SIZE-1:0]  data_o,
    output logic                  hit_o
);

    always_comb begin
        data_o = rf_data_i;
        hit_o  = 1'b0;
        if (addr_i != '0) begin
            if (exm_we_i && (exm_addr_i == addr_i)) begin
                data_o = exm_data_i;
                hit_o  = 1'b1;
            end else if (wb_we_i && (wb_addr_i == addr_i)) begin
                data_o = wb_data_i;
                hit_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: captures one decoded instruction, resolves its operands
// through the bypass network and holds MUL ops for a fixed settle budget.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int MUL_CYCLES = 3
) (
    input logic         clk,
    input logic         rst_n,
    alu_issue_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_CYCLES - 1);

    issue_state_t          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic                  use_imm_q, use_imm_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_we_q, rd_we_d;

    logic                  accept;
    logic [WORD_SIZE-1:0]  cap_a_fwd, cap_b_fwd, cap_a, cap_b;
    logic                  cap_a_hit, cap_b_hit;
    logic [WORD_SIZE-1:0]  snoop_a, snoop_b;
    logic                  snoop_a_hit, snoop_b_hit, late_hit;

    assign bus.in_ready = (state_q == EMPTY) || ((state_q == VALID) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    operand_bypass #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) u_cap_a (
        .addr_i     (bus.in_rs1_addr),
        .rf_data_i  (bus.in_rs1_data),
        .exm_we_i   (bus.exm_we),
        .exm_addr_i (bus.exm_addr),
        .exm_data_i (bus.exm_data),
        .wb_we_i    (bus.wb_we),
        .wb_addr_i  (bus.wb_addr),
        .wb_data_i  (bus.wb_data),
        .data_o     (cap_a_fwd),
        .hit_o      (cap_a_hit)
    );

    operand_bypass #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) u_cap_b (
        .addr_i     (bus.in_rs2_addr),
        .rf_data_i  (bus.in_rs2_data),
        .exm_we_i   (bus.exm_we),
        .exm_addr_i (bus.exm_addr),
        .exm_data_i (bus.exm_data),
        .wb_we_i    (bus.wb_we),
        .wb_addr_i  (bus.wb_addr),
        .wb_data_i  (bus.wb_data),
        .data_o     (cap_b_fwd),
        .hit_o      (cap_b_hit)
    );

    assign cap_a = cap_a_hit ? cap_a_fwd : bus.in_rs1_data;
    assign cap_b = cap_b_hit ? cap_b_fwd : bus.in_rs2_data;

    // Snoop instances fall back to the held operand, so a miss keeps it unchanged.
    operand_bypass #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) u_snoop_a (
        .addr_i     (rs1_q),
        .rf_data_i  (a_q),
        .exm_we_i   (bus.exm_we),
        .exm_addr_i (bus.exm_addr),
        .exm_data_i (bus.exm_data),
        .wb_we_i    (bus.wb_we),
        .wb_addr_i  (bus.wb_addr),
        .wb_data_i  (bus.wb_data),
        .data_o     (snoop_a),
        .hit_o      (snoop_a_hit)
    );

    operand_bypass #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) u_snoop_b (
        .addr_i     (rs2_q),
        .rf_data_i  (b_q),
        .exm_we_i   (bus.exm_we),
        .exm_addr_i (bus.exm_addr),
        .exm_data_i (bus.exm_data),
        .wb_we_i    (bus.wb_we),
        .wb_addr_i  (bus.wb_addr),
        .wb_data_i  (bus.wb_data),
        .data_o     (snoop_b),
        .hit_o      (snoop_b_hit)
    );

    assign late_hit = snoop_a_hit || (snoop_b_hit && !use_imm_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        rd_addr_d = rd_addr_q;
        rd_we_d   = rd_we_q;

        if (bus.flush) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else if (accept) begin
            a_d       = cap_a;
            b_d       = bus.in_use_imm ? bus.in_imm : cap_b;
            ctrl_d    = bus.in_ctrl;
            rs1_d     = bus.in_rs1_addr;
            rs2_d     = bus.in_rs2_addr;
            use_imm_d = bus.in_use_imm;
            rd_addr_d = bus.in_rd_addr;
            rd_we_d   = bus.in_rd_we;
            if ((bus.in_ctrl == MUL_OP) && (MUL_CYCLES > 1)) begin
                state_d = WAIT_MUL;
                cnt_d   = MUL_RELOAD;
            end else begin
                state_d = VALID;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                WAIT_MUL: begin
                    if (snoop_a_hit)                a_d = snoop_a;
                    if (snoop_b_hit && !use_imm_q)  b_d = snoop_b;
                    // A changed operand means the multiplier must settle again.
                    if (late_hit) begin
                        cnt_d = MUL_RELOAD;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_d = VALID;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                VALID: begin
                    if (bus.out_ready) begin
                        state_d = EMPTY;
                    end else begin
                        if (snoop_a_hit)                a_d = snoop_a;
                        if (snoop_b_hit && !use_imm_q)  b_d = snoop_b;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
            rd_addr_q <= '0;
            rd_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
            rd_addr_q <= rd_addr_d;
            rd_we_q   <= rd_we_d;
        end
    end

    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_ctrl    = ctrl_q;
    assign bus.out_valid   = (state_q == VALID);
    assign bus.out_rd_addr = rd_addr_q;
    assign bus.out_rd_we   = rd_we_q;

endmodule
